// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl
//   Key-entry sequencer for the keypad calculator. Turns keypad scanner key
//   events into two decimal operands and an operator, launches the ALU with a
//   start/done handshake, and supplies the value to display. A finished result
//   becomes operand A, so an operator pressed after a result chains into a new
//   operation.
//
//   Parameters
//     W       operand/result width (2^W must exceed 10^DIGITS)
//     DIGITS  maximum decimal digits per operand
//
//   Ports
//     IN_clk      system clock
//     IN_rst_n    asynchronous active-low reset
//     IN_key      scanner key-present level
//     IN_value    scanner key code: 0-9 digit, 10 add, 11 sub, 12 and,
//                 13 or, 14 cmp, 15 equals
//     IN_done     ALU completion pulse
//     IN_result   ALU result, valid while IN_done=1
//     OUT_a       operand A
//     OUT_b       operand B
//     OUT_op      operator: 0 add, 1 sub, 2 and, 3 or, 4 cmp
//     OUT_start   one-cycle ALU launch pulse
//     OUT_disp    value to display
//     OUT_err     digit-overflow flag
//     OUT_state   current state: 0 S_A, 1 S_OP, 2 S_B, 3 S_WAIT, 4 S_RES
//
//   Every output is taken straight from a register.
module calc_entry_ctrl #(
  parameter int W      = 16,
  parameter int DIGITS = 4
) (
  input  logic         IN_clk,
  input  logic         IN_rst_n,
  input  logic         IN_key,
  input  logic [3:0]   IN_value,
  input  logic         IN_done,
  input  logic [W-1:0] IN_result,
  output logic [W-1:0] OUT_a,
  output logic [W-1:0] OUT_b,
  output logic [2:0]   OUT_op,
  output logic         OUT_start,
  output logic [W-1:0] OUT_disp,
  output logic         OUT_err,
  output logic [2:0]   OUT_state
);

  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_OP   = 3'd1;
  localparam logic [2:0] S_B    = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RES  = 3'd4;

  localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [W-1:0]  TEN      = W'(10);

  logic          r_keyPrev;
  logic [2:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [CW-1:0] r_cntA;
  logic [CW-1:0] r_cntB;
  logic [2:0]    r_op;
  logic          r_err;
  logic          r_start;
  logic [W-1:0]  r_disp;

  logic [2:0]    w_stateNext;
  logic [W-1:0]  w_aNext;
  logic [W-1:0]  w_bNext;
  logic [CW-1:0] w_cntANext;
  logic [CW-1:0] w_cntBNext;
  logic [2:0]    w_opNext;
  logic          w_errNext;
  logic          w_startNext;
  logic [W-1:0]  w_dispNext;

  logic          w_event;
  logic          w_isDigit;
  logic          w_isOp;
  logic          w_isEq;
  logic [W-1:0]  w_digit;
  logic [2:0]    w_opCode;

  // A key event is the rising edge of the key-present level; holding a key
  // therefore yields a single event, and releases are never events.
  assign w_event   = IN_key & ~r_keyPrev;
  assign w_isDigit = (IN_value <= 4'd9);
  assign w_isEq    = (IN_value == 4'd15);
  assign w_isOp    = ~w_isDigit & ~w_isEq;
  assign w_digit   = W'(IN_value);
  assign w_opCode  = 3'(IN_value - 4'd10);

  // Next-state and next-datapath logic. S_WAIT ignores every key event and
  // takes IN_done with priority, so a key arriving in the same cycle as the
  // done (or as the exit from S_WAIT) is dropped. A loaded result gets a full
  // digit count so that it can only be replaced, never extended.
  always_comb begin
    w_stateNext = r_state;
    w_aNext     = r_a;
    w_bNext     = r_b;
    w_cntANext  = r_cntA;
    w_cntBNext  = r_cntB;
    w_opNext    = r_op;
    w_errNext   = r_err;
    w_startNext = 1'b0;

    case (r_state)
      S_A: begin
        if (w_event) begin
          if (w_isDigit) begin
            if (r_cntA == CNT_FULL) begin
              w_errNext = 1'b1;
            end else begin
              w_aNext    = r_a * TEN + w_digit;
              w_cntANext = r_cntA + CNT_ONE;
            end
          end else if (w_isOp) begin
            w_opNext    = w_opCode;
            w_bNext     = '0;
            w_cntBNext  = '0;
            w_errNext   = 1'b0;
            w_stateNext = S_OP;
          end
        end
      end

      S_OP: begin
        if (w_event) begin
          if (w_isDigit) begin
            w_bNext     = w_digit;
            w_cntBNext  = CNT_ONE;
            w_stateNext = S_B;
          end else if (w_isOp) begin
            w_opNext = w_opCode;
          end
        end
      end

      S_B: begin
        if (w_event) begin
          if (w_isDigit) begin
            if (r_cntB == CNT_FULL) begin
              w_errNext = 1'b1;
            end else begin
              w_bNext    = r_b * TEN + w_digit;
              w_cntBNext = r_cntB + CNT_ONE;
            end
          end else if (w_isEq) begin
            w_startNext = 1'b1;
            w_errNext   = 1'b0;
            w_stateNext = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (IN_done) begin
          w_aNext     = IN_result;
          w_cntANext  = CNT_FULL;
          w_stateNext = S_RES;
        end
      end

      S_RES: begin
        if (w_event) begin
          if (w_isDigit) begin
            w_aNext     = w_digit;
            w_cntANext  = CNT_ONE;
            w_errNext   = 1'b0;
            w_stateNext = S_A;
          end else if (w_isOp) begin
            w_opNext    = w_opCode;
            w_bNext     = '0;
            w_cntBNext  = '0;
            w_errNext   = 1'b0;
            w_stateNext = S_OP;
          end
        end
      end

      default: begin
        w_stateNext = S_A;
      end
    endcase

    // The display follows the operand being worked on in the state being
    // entered; during S_WAIT it freezes on whatever was last shown.
    w_dispNext = w_aNext;
    if (w_stateNext == S_B) begin
      w_dispNext = w_bNext;
    end else if (w_stateNext == S_WAIT) begin
      w_dispNext = r_disp;
    end
  end

  // State and output registers; reset clears everything, including the
  // key-edge history so a key held through reset counts as a fresh press.
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      r_keyPrev <= 1'b0;
      r_state   <= S_A;
      r_a       <= '0;
      r_b       <= '0;
      r_cntA    <= '0;
      r_cntB    <= '0;
      r_op      <= '0;
      r_err     <= 1'b0;
      r_start   <= 1'b0;
      r_disp    <= '0;
    end else begin
      r_keyPrev <= IN_key;
      r_state   <= w_stateNext;
      r_a       <= w_aNext;
      r_b       <= w_bNext;
      r_cntA    <= w_cntANext;
      r_cntB    <= w_cntBNext;
      r_op      <= w_opNext;
      r_err     <= w_errNext;
      r_start   <= w_startNext;
      r_disp    <= w_dispNext;
    end
  end

  assign OUT_a     = r_a;
  assign OUT_b     = r_b;
  assign OUT_op    = r_op;
  assign OUT_start = r_start;
  assign OUT_disp  = r_disp;
  assign OUT_err   = r_err;
  assign OUT_state = r_state;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl
//   Directed scenarios followed by random key sequences for calc_entry_ctrl.
//   A key-level reference model tracks what the calculator should show after
//   every key press, ALU completion and reset.
module tb_calc_entry_ctrl;

  localparam int W      = 16;
  localparam int DIGITS = 4;
  localparam int MASK   = (1 << W) - 1;

  logic         IN_clk = 1'b0;
  logic         IN_rst_n = 1'b0;
  logic         IN_key = 1'b0;
  logic [3:0]   IN_value = 4'd0;
  logic         IN_done = 1'b0;
  logic [W-1:0] IN_result = '0;
  logic [W-1:0] OUT_a;
  logic [W-1:0] OUT_b;
  logic [2:0]   OUT_op;
  logic         OUT_start;
  logic [W-1:0] OUT_disp;
  logic         OUT_err;
  logic [2:0]   OUT_state;

  int checks = 0;
  int failures = 0;

  // Reference model: calculator contents as seen by the user.
  int mState, mA, mB, mOp, mErr, mLenA, mLenB, mDisp, mStart;

  calc_entry_ctrl #(.W(W), .DIGITS(DIGITS)) dut (
    .IN_clk    (IN_clk),
    .IN_rst_n  (IN_rst_n),
    .IN_key    (IN_key),
    .IN_value  (IN_value),
    .IN_done   (IN_done),
    .IN_result (IN_result),
    .OUT_a     (OUT_a),
    .OUT_b     (OUT_b),
    .OUT_op    (OUT_op),
    .OUT_start (OUT_start),
    .OUT_disp  (OUT_disp),
    .OUT_err   (OUT_err),
    .OUT_state (OUT_state)
  );

  // Free-running clock, period 10.
  always #5 IN_clk = ~IN_clk;

  // Hard bound on total simulation time.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".state"}, 32'(OUT_state), mState);
    checkOutput({tag, ".a"},     32'(OUT_a),     mA);
    checkOutput({tag, ".b"},     32'(OUT_b),     mB);
    checkOutput({tag, ".op"},    32'(OUT_op),    mOp);
    checkOutput({tag, ".err"},   32'(OUT_err),   mErr);
    checkOutput({tag, ".disp"},  32'(OUT_disp),  mDisp);
    checkOutput({tag, ".start"}, 32'(OUT_start), mStart);
  endtask

  function automatic int aluRef(input int a, input int b, input int op);
    case (op)
      0:       return (a + b) & MASK;
      1:       return (a - b) & MASK;
      2:       return a & b;
      3:       return a | b;
      default: return (a < b) ? 1 : 0;
    endcase
  endfunction

  task automatic modelReset();
    mState = 0; mA = 0; mB = 0; mOp = 0; mErr = 0;
    mLenA = 0; mLenB = 0; mDisp = 0; mStart = 0;
  endtask

  task automatic modelOperator(input int v);
    mOp = v - 10; mB = 0; mLenB = 0; mErr = 0; mState = 1;
  endtask

  // One key event, described by what a user sees on the calculator.
  task automatic modelKey(input int v);
    bit digit, oper, equals;
    digit  = (v < 10);
    equals = (v == 15);
    oper   = !digit && !equals;
    mStart = 0;
    if (mState == 0) begin
      if (digit) begin
        if (mLenA >= DIGITS) mErr = 1;
        else begin mA = mA * 10 + v; mLenA++; end
      end else if (oper) modelOperator(v);
    end else if (mState == 1) begin
      if (digit) begin mB = v; mLenB = 1; mState = 2; end
      else if (oper) mOp = v - 10;
    end else if (mState == 2) begin
      if (digit) begin
        if (mLenB >= DIGITS) mErr = 1;
        else begin mB = mB * 10 + v; mLenB++; end
      end else if (equals) begin
        mState = 3; mStart = 1; mErr = 0;
      end
    end else if (mState == 4) begin
      if (digit) begin mA = v; mLenA = 1; mErr = 0; mState = 0; end
      else if (oper) modelOperator(v);
    end
    if (mState == 2) mDisp = mB;
    else if (mState != 3) mDisp = mA;
  endtask

  // Press key v, hold it for 'hold' cycles, release, then one idle cycle.
  task automatic applyStimulus(input int v, input int hold = 1);
    @(negedge IN_clk);
    IN_key = 1'b1;
    IN_value = 4'(v);
    @(posedge IN_clk);
    modelKey(v);
    @(negedge IN_clk);
    checkAll($sformatf("key%0d", v));
    for (int i = 1; i < hold; i++) begin
      @(posedge IN_clk);
      mStart = 0;
      @(negedge IN_clk);
      checkAll($sformatf("hold%0d", v));
    end
    IN_key = 1'b0;
    @(posedge IN_clk);
    mStart = 0;
  endtask

  // One IN_done pulse; it matters only while the model is waiting.
  task automatic pulseDone(input int res);
    @(negedge IN_clk);
    IN_done = 1'b1;
    IN_result = W'(res);
    @(posedge IN_clk);
    if (mState == 3) begin
      mA = res; mLenA = DIGITS; mState = 4; mDisp = res;
    end
    @(negedge IN_clk);
    IN_done = 1'b0;
    checkAll("done");
  endtask

  // ALU answers 'delay' cycles after the start pulse.
  task automatic serviceAlu(input int delay, input int res);
    @(negedge IN_clk);
    checkOutput("startLow", 32'(OUT_start), 0);
    checkOutput("waitState", 32'(OUT_state), 3);
    repeat (delay - 2) @(negedge IN_clk);
    pulseDone(res);
  endtask

  // Reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic doReset();
    @(posedge IN_clk);
    #2;
    IN_rst_n = 1'b0;
    IN_key = 1'b0;
    IN_done = 1'b0;
    modelReset();
    #1;
    checkAll("reset");
    repeat (2) @(negedge IN_clk);
    IN_rst_n = 1'b1;
    @(posedge IN_clk);
  endtask

  initial begin
    int v;
    $display("[TB] starting calc_entry_ctrl bench");
    modelReset();
    doReset();

    // First operation after reset: 5 + 3.
    applyStimulus(5); applyStimulus(10); applyStimulus(3); applyStimulus(15);
    serviceAlu(2, 8);

    // 12 + 3 with the ALU answering three cycles after start.
    applyStimulus(1); applyStimulus(2); applyStimulus(10); applyStimulus(3);
    applyStimulus(15);
    serviceAlu(3, 15);

    // Chain from result 15; sub replaces add before B is typed.
    applyStimulus(10); applyStimulus(11); applyStimulus(5); applyStimulus(15);
    serviceAlu(2, 10);
    applyStimulus(7);

    // Digit overflow on A, cleared by an operator.
    doReset();
    for (int i = 1; i <= 5; i++) applyStimulus(i);
    applyStimulus(12);

    // Held key gives one digit; keys during the wait are dropped.
    applyStimulus(7, 20);
    applyStimulus(15);
    applyStimulus(4); applyStimulus(10); applyStimulus(15);
    serviceAlu(4, aluRef(mA, mB, mOp));

    // Stray done while entering A.
    applyStimulus(4);
    pulseDone(999);

    // Reset while waiting for the ALU, then a late done.
    applyStimulus(10); applyStimulus(2); applyStimulus(15);
    doReset();
    pulseDone(1234);

    // Random key sequences.
    for (int n = 0; n < 300; n++) begin
      if (mState == 3) begin
        if ($urandom_range(0, 3) == 0) applyStimulus($urandom_range(0, 15));
        serviceAlu($urandom_range(2, 5), aluRef(mA, mB, mOp));
      end else begin
        if ($urandom_range(0, 2) != 0) v = $urandom_range(0, 9);
        else v = $urandom_range(10, 15);
        applyStimulus(v, $urandom_range(1, 3));
        if ($urandom_range(0, 40) == 0) doReset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Key-entry sequencer for the keypad calculator. It sits between the 4x4 keypad scanner and the arithmetic/logic unit. It turns scanner key events into two decimal operands and an operator, launches the ALU with a start/done handshake, and supplies the value to display. Results can be chained into a further operation.

## Interface
- W, 16, operand/result width; must satisfy 2^W > 10^DIGITS
- DIGITS, 4, maximum decimal digits per operand
- IN_clk  in  1  system clock
- IN_rst_n  in  1  reset; asynchronous, active-low
- IN_key  in  1  scanner key-present level
- IN_value  in  4  scanner key code: 0-9 digit, 10 add, 11 sub, 12 and, 13 or, 14 cmp, 15 equals
- IN_done  in  1  ALU completion pulse
- IN_result  in  W  ALU result, valid while IN_done=1
- OUT_a  out  W  operand A
- OUT_b  out  W  operand B
- OUT_op  out  3  operator: 0 add, 1 sub, 2 and, 3 or, 4 cmp
- OUT_start  out  1  ALU launch pulse, one cycle
- OUT_disp  out  W  value to display
- OUT_err  out  1  digit-overflow flag
- OUT_state  out  3  current state: 0 S_A, 1 S_OP, 2 S_B, 3 S_WAIT, 4 S_RES

## Operation
- **Key event:** an event occurs when IN_key=1 and the registered IN_key from the previous cycle is 0. IN_value is sampled on that same cycle.
  - A held key produces exactly one event.
  - IN_key falling edges are ignored.
- **Digit accumulate:** X <= X*10 + d, and the digit count increments.
  - Arithmetic is W bits. Overflow cannot occur because the digit count is limited to DIGITS.
  - A digit arriving when the count equals DIGITS is dropped, and OUT_err <= 1.
- **S_A (entering A):**
  - Digit: accumulate into A.
  - Operator: OUT_op <= code-10; B <= 0; B count <= 0; OUT_err <= 0; go to S_OP.
  - Equals: ignored.
- **S_OP (operator entered, no B digits yet):**
  - Digit: B <= d; count <= 1; go to S_B.
  - Operator: replaces OUT_op and stays in S_OP.
  - Equals: ignored.
- **S_B (entering B):**
  - Digit: accumulate into B.
  - Operator: ignored.
  - Equals: OUT_start <= 1; OUT_err <= 0; go to S_WAIT.
- **S_WAIT:**
  - All key events are dropped.
  - On IN_done: A <= IN_result; A count <= DIGITS (a result cannot be extended with digits); go to S_RES.
- **S_RES (result shown):**
  - Digit: A <= d; count <= 1; OUT_err <= 0; go to S_A.
  - Operator: chains, handled exactly as an operator in S_A; go to S_OP.
  - Equals: ignored.
- **OUT_disp:**
  - A in S_A, S_OP and S_RES.
  - B in S_B.
  - In S_WAIT, holds its last value.
- **IN_done outside S_WAIT:** ignored.
- **Reset (async assert):**
  - All outputs and counts go to 0; state goes to S_A; OUT_op = 0; the key-edge register = 0.
  - This applies mid-operation too, including during S_WAIT. A later IN_done is then ignored.

## Timing
- The event is detected on edge N, where IN_key is first sampled high. OUT_a, OUT_b, OUT_op, OUT_disp and OUT_state update on that same edge and are visible in cycle N+1.
- OUT_start is high for exactly one cycle: the cycle S_WAIT is entered. OUT_a, OUT_b and OUT_op are valid that cycle and stay stable until IN_done is accepted.
- IN_done is accepted at the earliest in the cycle after OUT_start. OUT_disp shows the result one cycle after IN_done.
- If IN_done and a key event occur in the same cycle in S_WAIT, the done is taken and the key is dropped.
- A key event sampled in the same cycle that S_WAIT is exited is processed under S_WAIT rules, so it is dropped.
- No combinational path from inputs to outputs; every output is registered.

## Test plan
- **Reset:** assert IN_rst_n=0 mid-cycle -> all outputs 0 immediately and OUT_state=0. Deassert, then keys 5,A,3,F -> OUT_a=5, OUT_b=3, OUT_op=0, single OUT_start pulse.
- **Basic operation:** keys 1,2,A,3,F; ALU returns IN_done with IN_result=15 three cycles after start -> OUT_a=12 and OUT_b=3 during start; OUT_disp=15 and OUT_state=4 afterwards.
- **Overflow:** keys 1,2,3,4,5 -> OUT_a=1234, OUT_err=1. Then key C -> OUT_err=0, OUT_op=2.
- **Chaining and replacement:** after result 15, keys A,B,5,F -> OUT_op=1 (B replaced A), OUT_a=15, OUT_b=5. Then digit 7 in S_RES -> OUT_a=7, OUT_state=0.
- **Held key and drops:** IN_key held 20 cycles with IN_value=7 -> exactly one digit accepted. Keys pressed during S_WAIT are ignored. IN_done while in S_A is ignored.
- **Reset during wait:** assert reset in S_WAIT, release, then pulse IN_done -> no state change, OUT_a=0.
